// File: rtl/ram_ws.sv
// Single-port word RAM behind a wait-state controller with a shared tri-state data bus.
// Each access runs IDLE -> WAIT (WAIT_STATES extra cycles) -> DONE, then returns to IDLE.
module ram_ws #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] a,
  inout  wire  [DATA_W-1:0] d,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                err_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                in_range_d;
  logic [IDX_W-1:0]    idx_d;
  logic                commit_d;

  assign in_range_d = (32'(addr_q) < 32'(DEPTH));
  assign idx_d      = addr_q[IDX_W-1:0];
  // Commit happens on the edge that leaves WAIT, so a reset during WAIT drops the write.
  assign commit_d   = (state_q == WAIT) && (cnt_q == 4'd0) && we_q && in_range_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req) begin
            addr_q  <= a;
            we_q    <= we;
            if (we) wdata_q <= d;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            ready_q <= 1'b1;
            err_q   <= !in_range_d;
            if (!we_q) rdata_q <= in_range_d ? mem_q[idx_d] : '0;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory has no reset so preloaded contents survive rst.
  always_ff @(posedge clk) begin
    if (commit_d) mem_q[idx_d] <= wdata_q;
  end

  assign d     = ((state_q == DONE) && !we_q) ? rdata_q : {DATA_W{1'bz}};
  assign ready = ready_q;
  assign err   = err_q;

endmodule
